// File: rtl/lr35902_dbg_arb.sv
// Round-robin owner of the CPU debug-injection port for NUM_REQ masters.
// Keeps the CPU halted in a guard gap between owners and takes the port back from an owner that holds it too long.
module lr35902_dbg_arb #(
  parameter int NUM_REQ  = 2,
  parameter int GUARD    = 4,
  parameter int MAX_HOLD = 255
) (
  input  logic                   cpu_clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [8*NUM_REQ-1:0]   i_req_data,
  input  logic [NUM_REQ-1:0]     i_req_drv,
  input  logic [NUM_REQ-1:0]     i_req_halt,
  input  logic [NUM_REQ-1:0]     i_req_no_inc,
  output logic [NUM_REQ-1:0]     o_gnt,
  output logic [7:0]             o_data,
  output logic                   o_drv,
  output logic                   o_halt,
  output logic                   o_no_inc,
  output logic [1:0]             o_owner,
  output logic                   o_busy
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_OWN = 2'd1, S_HAND = 2'd2} state_t;

  localparam logic [7:0] LP_MAX_HOLD = 8'(MAX_HOLD);
  localparam logic [3:0] LP_GUARD    = 4'(GUARD);
  localparam logic [1:0] LP_RR_INIT  = 2'(NUM_REQ - 1);

  state_t             r_state, w_state_next;
  logic [1:0]         r_owner, w_owner_next;
  logic [1:0]         r_rr, w_rr_next;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_next;
  logic [7:0]         r_data, w_data_next;
  logic               r_drv, w_drv_next;
  logic               r_halt, w_halt_next;
  logic               r_no_inc, w_no_inc_next;
  logic [7:0]         r_hold, w_hold_next;
  logic [3:0]         r_guard, w_guard_next;
  logic [3:0]         r_revoked, w_revoked_next;

  logic [3:0]         w_req4, w_drv4, w_halt4, w_no_inc4;
  logic [7:0]         w_dat4 [0:3];
  logic [3:0]         w_cand, w_owner_bit, w_pick_bit;
  logic [1:0]         w_pick;
  logic               w_any, w_others, w_own_req, w_revoke;
  logic [7:0]         w_hold_inc;

  // Pad requester vectors to four slots so every lookup is indexed by the 2-bit owner.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pad
      if (gi < NUM_REQ) begin : g_used
        assign w_req4[gi]    = i_req[gi];
        assign w_drv4[gi]    = i_req_drv[gi];
        assign w_halt4[gi]   = i_req_halt[gi];
        assign w_no_inc4[gi] = i_req_no_inc[gi];
        assign w_dat4[gi]    = i_req_data[8*gi +: 8];
      end else begin : g_unused
        assign w_req4[gi]    = 1'b0;
        assign w_drv4[gi]    = 1'b0;
        assign w_halt4[gi]   = 1'b0;
        assign w_no_inc4[gi] = 1'b0;
        assign w_dat4[gi]    = 8'h00;
      end
    end
  endgenerate

  function automatic logic [1:0] f_pick(input logic [3:0] cand, input logic [1:0] base);
    logic [1:0] v_sel;
    int         v_idx;
    v_sel = base;
    for (int k = NUM_REQ; k >= 1; k--) begin
      v_idx = int'(base) + k;
      if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
      if (cand[2'(v_idx)]) v_sel = 2'(v_idx);
    end
    return v_sel;
  endfunction

  // The hold counter also runs while the owner drives, so revocation fires as soon as driving stops.
  always_comb begin
    w_cand      = w_req4 & ~r_revoked;
    w_pick      = f_pick(w_cand, r_rr);
    w_pick_bit  = 4'b0001 << w_pick;
    w_owner_bit = 4'b0001 << r_owner;
    w_any       = |w_cand;
    w_others    = |(w_cand & ~w_owner_bit);
    w_own_req   = w_req4[r_owner];
    w_hold_inc  = (r_hold == 8'hFF) ? r_hold : r_hold + 8'd1;
    w_revoke    = (MAX_HOLD != 0) && (r_state == S_OWN) && w_own_req && w_others &&
                  !w_drv4[r_owner] && (w_hold_inc >= LP_MAX_HOLD);
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_owner   <= 2'd0;
      r_rr      <= LP_RR_INIT;
      r_gnt     <= '0;
      r_data    <= 8'h00;
      r_drv     <= 1'b0;
      r_halt    <= 1'b0;
      r_no_inc  <= 1'b0;
      r_hold    <= 8'd0;
      r_guard   <= 4'd0;
      r_revoked <= 4'd0;
    end else begin
      r_state   <= w_state_next;
      r_owner   <= w_owner_next;
      r_rr      <= w_rr_next;
      r_gnt     <= w_gnt_next;
      r_data    <= w_data_next;
      r_drv     <= w_drv_next;
      r_halt    <= w_halt_next;
      r_no_inc  <= w_no_inc_next;
      r_hold    <= w_hold_next;
      r_guard   <= w_guard_next;
      r_revoked <= w_revoked_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_owner_next   = r_owner;
    w_rr_next      = r_rr;
    w_gnt_next     = r_gnt;
    w_data_next    = r_data;
    w_drv_next     = r_drv;
    w_halt_next    = r_halt;
    w_no_inc_next  = r_no_inc;
    w_hold_next    = r_hold;
    w_guard_next   = r_guard;
    w_revoked_next = (r_revoked & w_req4) | (w_revoke ? w_owner_bit : 4'b0000);
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_next = S_OWN;
          w_owner_next = w_pick;
          w_rr_next    = w_pick;
          w_gnt_next   = w_pick_bit[NUM_REQ-1:0];
          w_hold_next  = 8'd0;
        end
      end
      S_OWN: begin
        if (!w_own_req) begin
          w_gnt_next  = '0;
          w_drv_next  = 1'b0;
          w_data_next = 8'h00;
          w_hold_next = 8'd0;
          if (r_halt) begin
            w_state_next = S_HAND;
            w_guard_next = LP_GUARD;
          end else begin
            w_state_next  = S_IDLE;
            w_no_inc_next = 1'b0;
          end
        end else if (w_revoke) begin
          w_state_next = S_HAND;
          w_guard_next = LP_GUARD;
          w_gnt_next   = '0;
          w_drv_next   = 1'b0;
          w_data_next  = 8'h00;
          w_halt_next  = 1'b1;
          w_hold_next  = 8'd0;
        end else begin
          w_data_next   = w_dat4[r_owner];
          w_drv_next    = w_drv4[r_owner];
          w_halt_next   = w_halt4[r_owner];
          w_no_inc_next = w_no_inc4[r_owner];
          w_hold_next   = w_others ? w_hold_inc : 8'd0;
        end
      end
      S_HAND: begin
        if (r_guard <= 4'd1) begin
          if (w_any) begin
            // Halt stays asserted across the grant; the new owner's controls arrive next cycle.
            w_state_next = S_OWN;
            w_owner_next = w_pick;
            w_rr_next    = w_pick;
            w_gnt_next   = w_pick_bit[NUM_REQ-1:0];
            w_hold_next  = 8'd0;
          end else begin
            w_state_next  = S_IDLE;
            w_halt_next   = 1'b0;
            w_no_inc_next = 1'b0;
          end
        end else begin
          w_guard_next = r_guard - 4'd1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_gnt    = r_gnt;
    o_data   = r_data;
    o_drv    = r_drv;
    o_halt   = r_halt;
    o_no_inc = r_no_inc;
    o_owner  = r_owner;
    o_busy   = (r_state != S_IDLE);
  end

endmodule

// File: tb/tb_lr35902_dbg_arb.sv
// Bench for lr35902_dbg_arb: directed hand-over/revocation/reset scenarios plus random traffic,
// all checked every cycle against a cycle-level behavioural model of the arbitration rules.
module tb_lr35902_dbg_arb;
  localparam int N        = 3;
  localparam int GUARD    = 4;
  localparam int MAX_HOLD = 8;
  localparam int PH_IDLE  = 0;
  localparam int PH_OWN   = 1;
  localparam int PH_HAND  = 2;

  logic           cpu_clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0, drv = '0, halt = '0, ninc = '0;
  logic [8*N-1:0] rdata = '0;

  logic [N-1:0]   d_gnt;
  logic [7:0]     d_data;
  logic           d_drv, d_halt, d_no_inc, d_busy;
  logic [1:0]     d_owner;

  int n_tests = 0;
  int n_fail  = 0;

  lr35902_dbg_arb #(.NUM_REQ(N), .GUARD(GUARD), .MAX_HOLD(MAX_HOLD)) dut (
    .cpu_clk(cpu_clk), .reset(reset),
    .i_req(req), .i_req_data(rdata), .i_req_drv(drv), .i_req_halt(halt), .i_req_no_inc(ninc),
    .o_gnt(d_gnt), .o_data(d_data), .o_drv(d_drv), .o_halt(d_halt), .o_no_inc(d_no_inc),
    .o_owner(d_owner), .o_busy(d_busy)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: expected outputs after each edge.
  bit           m_valid = 0;
  int           m_phase, m_owner, m_last, m_waited, m_left;
  logic [N-1:0] m_banned, e_gnt;
  logic [7:0]   e_data;
  logic         e_drv, e_halt, e_ninc;

  function automatic int pick_from(input logic [N-1:0] cand, input int last);
    for (int k = 1; k <= N; k++) begin
      if (cand[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_grant(input int p);
    m_owner  = p;
    m_last   = p;
    m_phase  = PH_OWN;
    m_waited = 0;
    e_gnt    = '0;
    e_gnt[p] = 1'b1;
  endtask

  always @(posedge cpu_clk) begin : model
    logic [N-1:0] cand, newban, others;
    int p;
    if (reset) begin
      m_valid = 1; m_phase = PH_IDLE; m_owner = 0; m_last = N - 1;
      m_waited = 0; m_left = 0; m_banned = '0;
      e_gnt = '0; e_data = 8'h00; e_drv = 0; e_halt = 0; e_ninc = 0;
    end else if (m_valid) begin
      cand   = req & ~m_banned;
      newban = '0;
      p      = pick_from(cand, m_last);
      case (m_phase)
        PH_IDLE: if (p >= 0) model_grant(p);
        PH_OWN: begin
          others = cand;
          others[m_owner] = 1'b0;
          if (!req[m_owner]) begin
            e_gnt = '0; e_drv = 0; e_data = 8'h00;
            if (e_halt) begin m_phase = PH_HAND; m_left = GUARD; end
            else begin m_phase = PH_IDLE; e_ninc = 0; end
          end else begin
            m_waited = (others != 0) ? ((m_waited + 1 > 255) ? 255 : m_waited + 1) : 0;
            if (MAX_HOLD != 0 && others != 0 && !drv[m_owner] && m_waited >= MAX_HOLD) begin
              newban[m_owner] = 1'b1;
              m_phase = PH_HAND; m_left = GUARD;
              e_gnt = '0; e_drv = 0; e_data = 8'h00; e_halt = 1;
            end else begin
              e_data = rdata[8*m_owner +: 8];
              e_drv  = drv[m_owner];
              e_halt = halt[m_owner];
              e_ninc = ninc[m_owner];
            end
          end
        end
        default: begin
          m_left--;
          if (m_left == 0) begin
            if (p >= 0) model_grant(p);
            else begin m_phase = PH_IDLE; e_halt = 0; e_ninc = 0; end
          end
        end
      endcase
      m_banned = (m_banned & req) | newban;
    end
  end

  always @(negedge cpu_clk) begin : compare
    if (m_valid) begin
      chk("gnt",    32'(d_gnt), 32'(e_gnt));
      chk("data",   32'(d_data), 32'(e_data));
      chk("drv",    32'(d_drv), 32'(e_drv));
      chk("halt",   32'(d_halt), 32'(e_halt));
      chk("no_inc", 32'(d_no_inc), 32'(e_ninc));
      chk("owner",  32'(d_owner), m_owner);
      chk("busy",   32'(d_busy), 32'(m_phase != PH_IDLE));
      chk("gnt_onehot0", 32'($onehot0(d_gnt)), 1);
      chk("drv_only_own", 32'(!d_drv || (d_gnt != '0)), 1);
    end
  end

  task automatic tick();
    @(negedge cpu_clk);
  endtask

  task automatic do_reset();
    reset = 1; req = '0; drv = '0; halt = '0; ninc = '0; rdata = '0;
    tick(); tick();
    reset = 0;
  endtask

  initial begin
    do_reset();
    chk("rst_gnt", 32'(d_gnt), 0);
    chk("rst_owner", 32'(d_owner), 0);
    chk("rst_busy", 32'(d_busy), 0);

    // Single master grant, then halted hand-over to a waiting master.
    req = 3'b001; halt = 3'b001; drv = 3'b001; rdata[7:0] = 8'h76;
    tick();
    chk("t1_gnt", 32'(d_gnt), 1);
    chk("t1_drv_early", 32'(d_drv), 0);
    tick();
    chk("t1_halt", 32'(d_halt), 1);
    chk("t1_drv", 32'(d_drv), 1);
    chk("t1_data", 32'(d_data), 32'h76);
    req = 3'b011; rdata[15:8] = 8'h11;
    tick(); tick();
    req = 3'b010;
    for (int i = 0; i < GUARD; i++) begin
      tick();
      chk("t3_hand_gnt", 32'(d_gnt), 0);
      chk("t3_hand_halt", 32'(d_halt), 1);
      chk("t3_hand_drv", 32'(d_drv), 0);
    end
    tick();
    chk("t3_gnt", 32'(d_gnt), 2);
    chk("t3_halt_kept", 32'(d_halt), 1);

    // Unhalted release goes through IDLE before the next grant.
    do_reset();
    req = 3'b011;
    tick();
    chk("t2_gnt0", 32'(d_gnt), 1);
    req = 3'b010;
    tick();
    chk("t2_idle_gnt", 32'(d_gnt), 0);
    chk("t2_idle_busy", 32'(d_busy), 0);
    tick();
    chk("t2_gnt1", 32'(d_gnt), 2);
    chk("t2_owner", 32'(d_owner), 1);

    // Revocation of an idle hog and its exclusion until it toggles req.
    do_reset();
    req = 3'b011; halt = 3'b001;
    for (int i = 0; i < MAX_HOLD; i++) begin
      tick();
      chk("t4_held", 32'(d_gnt), 1);
    end
    tick();
    chk("t4_revoked", 32'(d_gnt), 0);
    chk("t4_hand_halt", 32'(d_halt), 1);
    for (int i = 0; i < GUARD - 1; i++) begin
      tick();
      chk("t4_hand_gnt", 32'(d_gnt), 0);
    end
    tick();
    chk("t4_gnt1", 32'(d_gnt), 2);
    tick(); tick();
    req = 3'b001;
    tick();
    chk("t4_idle_gnt", 32'(d_gnt), 0);
    chk("t4_idle_busy", 32'(d_busy), 0);
    tick(); tick();
    chk("t4_no_regrant", 32'(d_gnt), 0);
    req = 3'b000;
    tick();
    req = 3'b001;
    tick();
    chk("t4_regrant", 32'(d_gnt), 1);

    // Driving owner is never revoked; it goes as soon as it stops driving.
    do_reset();
    req = 3'b011; drv = 3'b001;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t5_kept", 32'(d_gnt), 1);
    end
    drv = 3'b000;
    tick();
    chk("t5_revoked", 32'(d_gnt), 0);

    // Reset in HAND and in OWN with drv=1.
    do_reset();
    req = 3'b001; halt = 3'b001; drv = 3'b001; ninc = 3'b001;
    tick(); tick();
    req = 3'b000;
    tick();
    chk("t6_hand_busy", 32'(d_busy), 1);
    chk("t6_hand_noinc", 32'(d_no_inc), 1);
    reset = 1;
    tick();
    chk("t6a_gnt", 32'(d_gnt), 0);
    chk("t6a_halt", 32'(d_halt), 0);
    chk("t6a_no_inc", 32'(d_no_inc), 0);
    chk("t6a_busy", 32'(d_busy), 0);
    reset = 0; req = 3'b001;
    tick(); tick();
    chk("t6_own_drv", 32'(d_drv), 1);
    reset = 1;
    tick();
    chk("t6b_gnt", 32'(d_gnt), 0);
    chk("t6b_drv", 32'(d_drv), 0);
    chk("t6b_halt", 32'(d_halt), 0);
    chk("t6b_no_inc", 32'(d_no_inc), 0);
    chk("t6b_busy", 32'(d_busy), 0);
    reset = 0;

    // Random traffic with sticky requests so ownership, hand-over and revocation all occur.
    req = '0; drv = '0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7) == 0) req[i] = ~req[i];
        if ($urandom_range(3) == 0) drv[i] = ~drv[i];
      end
      halt  = 3'($urandom);
      ninc  = 3'($urandom);
      rdata = 24'($urandom);
      reset = ($urandom_range(399) == 0);
      tick();
    end
    reset = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
